// File: rtl/fmap_streamer3.sv
// fmap_streamer3
// Streams one 3-channel MAP_SIZE x MAP_SIZE feature map from three
// parallel memory banks into a KERNEL x KERNEL x 3 convolution consumer.
// Pixels are read in row-major order and presented on next0..2 with en.
// The streamer also flags which consumer results correspond to windows
// lying fully inside the map, and gives their output-map coordinates.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start                  one-cycle request to stream a map (ignored while busy)
//   mem_rd, mem_addr       read strobe and row-major address to all banks
//   mem_data0..2           bank read data, valid one cycle after mem_rd
//   next0..2, en           pixel stream and latch enable for the consumer
//   out_valid              consumer result this cycle is a fully-inside window
//   out_row, out_col       output-map coordinate of that window (0 otherwise)
//   busy                   high while reading or draining
//   done                   one-cycle completion pulse
module fmap_streamer3 #(
    parameter int BIT_WIDTH  = 8,
    parameter int MAP_SIZE   = 14,
    parameter int KERNEL     = 5,
    parameter int ADDR_WIDTH = 8,
    parameter int CONV_LAT   = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    output logic                                   mem_rd,
    output logic [ADDR_WIDTH-1:0]                  mem_addr,
    input  logic signed [BIT_WIDTH-1:0]            mem_data0,
    input  logic signed [BIT_WIDTH-1:0]            mem_data1,
    input  logic signed [BIT_WIDTH-1:0]            mem_data2,
    output logic signed [BIT_WIDTH-1:0]            next0,
    output logic signed [BIT_WIDTH-1:0]            next1,
    output logic signed [BIT_WIDTH-1:0]            next2,
    output logic                                   en,
    output logic                                   out_valid,
    output logic [$clog2(MAP_SIZE-KERNEL+1)-1:0]   out_row,
    output logic [$clog2(MAP_SIZE-KERNEL+1)-1:0]   out_col,
    output logic                                   busy,
    output logic                                   done
);

    localparam int N  = MAP_SIZE * MAP_SIZE;
    localparam int OW = $clog2(MAP_SIZE - KERNEL + 1);
    localparam int RW = $clog2(MAP_SIZE);
    localparam int DW = $clog2(CONV_LAT + 3);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [RW-1:0]         rd_row, rd_col;
    logic [DW-1:0]         drain_cnt;

    logic                  s1_valid;
    logic [RW-1:0]         s1_row, s1_col;
    logic [RW-1:0]         s2_row, s2_col;

    logic                  win_valid;
    logic [OW-1:0]         win_row, win_col;

    logic [CONV_LAT-1:0]   vpipe;
    logic [OW-1:0]         rpipe [CONV_LAT];
    logic [OW-1:0]         cpipe [CONV_LAT];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // DRAIN lasts CONV_LAT+2 cycles: two for the read/register stages of the
    // last pixel and CONV_LAT for its window flag to reach out_valid.
    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = READ;
            end
            READ: begin
                mem_rd   = 1'b1;
                mem_addr = rd_addr;
                busy     = 1'b1;
                if (rd_addr == ADDR_WIDTH'(N - 1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DW'(CONV_LAT + 1)) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address and pixel row/column advance together, one pixel per READ cycle;
    // outside READ they sit at zero so every run starts at pixel 0.
    always_ff @(posedge clk) begin
        if (rst || state != READ) begin
            rd_addr <= '0;
            rd_row  <= '0;
            rd_col  <= '0;
        end else begin
            rd_addr <= rd_addr + 1'b1;
            if (rd_col == RW'(MAP_SIZE - 1)) begin
                rd_col <= '0;
                rd_row <= rd_row + 1'b1;
            end else begin
                rd_col <= rd_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state != DRAIN) drain_cnt <= '0;
        else                       drain_cnt <= drain_cnt + 1'b1;
    end

    // Stage 1 tracks the cycle the bank data is on the bus; stage 2 is the
    // registered pixel seen by the consumer together with its coordinate.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_row   <= '0;
            s1_col   <= '0;
            en       <= 1'b0;
            next0    <= '0;
            next1    <= '0;
            next2    <= '0;
            s2_row   <= '0;
            s2_col   <= '0;
        end else begin
            s1_valid <= mem_rd;
            s1_row   <= rd_row;
            s1_col   <= rd_col;
            en       <= s1_valid;
            if (s1_valid) begin
                next0  <= mem_data0;
                next1  <= mem_data1;
                next2  <= mem_data2;
                s2_row <= s1_row;
                s2_col <= s1_col;
            end
        end
    end

    // A window is fully inside once the newest pixel is at least KERNEL-1
    // rows and columns into the map; its output coordinate is its top-left.
    always_comb begin
        win_valid = en && (s2_row >= RW'(KERNEL - 1)) && (s2_col >= RW'(KERNEL - 1));
        win_row   = '0;
        win_col   = '0;
        if (win_valid) begin
            win_row = OW'(s2_row - RW'(KERNEL - 1));
            win_col = OW'(s2_col - RW'(KERNEL - 1));
        end
    end

    // Delay the window flag and coordinate to line up with the consumer result.
    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe <= '0;
            for (int i = 0; i < CONV_LAT; i++) begin
                rpipe[i] <= '0;
                cpipe[i] <= '0;
            end
        end else begin
            vpipe[0] <= win_valid;
            rpipe[0] <= win_row;
            cpipe[0] <= win_col;
            for (int i = 1; i < CONV_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
                rpipe[i] <= rpipe[i-1];
                cpipe[i] <= cpipe[i-1];
            end
        end
    end

    assign out_valid = vpipe[CONV_LAT-1];
    assign out_row   = rpipe[CONV_LAT-1];
    assign out_col   = cpipe[CONV_LAT-1];

endmodule

// File: tb/tb_fmap_streamer3.sv
// tb_fmap_streamer3
// Drives two streamers (CONV_LAT=1 and CONV_LAT=3) with the same start/rst
// schedule and bank memories, and checks every output every cycle against
// a behavioural model derived from each run's start cycle.
module tb_fmap_streamer3;

    localparam int M = 14;
    localparam int K = 5;
    localparam int N = M * M;
    localparam int MAXC = 2048;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;

    logic              rd_a, rd_b;
    logic [7:0]        addr_a, addr_b;
    logic signed [7:0] md0_a = 0, md1_a = 0, md2_a = 0;
    logic signed [7:0] md0_b = 0, md1_b = 0, md2_b = 0;
    logic signed [7:0] n0_a, n1_a, n2_a, n0_b, n1_b, n2_b;
    logic              en_a, en_b, ov_a, ov_b, busy_a, busy_b, done_a, done_b;
    logic [3:0]        row_a, col_a, row_b, col_b;

    logic signed [7:0] bank0 [256];
    logic signed [7:0] bank1 [256];
    logic signed [7:0] bank2 [256];

    bit start_s [MAXC];
    bit rst_s   [MAXC];

    int compared = 0;
    int mismatched = 0;
    int scen = 0;
    int run_start [2];
    int last_next [2][3];
    int lat [2];
    int ov_cnt_a, ov_cnt_b, rd_cnt_a, done_cnt_a;

    always #5 clk = ~clk;

    fmap_streamer3 dut_a (
        .clk(clk), .rst(rst), .start(start),
        .mem_rd(rd_a), .mem_addr(addr_a),
        .mem_data0(md0_a), .mem_data1(md1_a), .mem_data2(md2_a),
        .next0(n0_a), .next1(n1_a), .next2(n2_a),
        .en(en_a), .out_valid(ov_a), .out_row(row_a), .out_col(col_a),
        .busy(busy_a), .done(done_a)
    );

    fmap_streamer3 #(.CONV_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start),
        .mem_rd(rd_b), .mem_addr(addr_b),
        .mem_data0(md0_b), .mem_data1(md1_b), .mem_data2(md2_b),
        .next0(n0_b), .next1(n1_b), .next2(n2_b),
        .en(en_b), .out_valid(ov_b), .out_row(row_b), .out_col(col_b),
        .busy(busy_b), .done(done_b)
    );

    // Bank memories: read data appears one cycle after the strobe.
    always @(posedge clk) begin
        if (rd_a) begin
            md0_a <= bank0[addr_a];
            md1_a <= bank1[addr_a];
            md2_a <= bank2[addr_a];
        end
        if (rd_b) begin
            md0_b <= bank0[addr_b];
            md1_b <= bank1[addr_b];
            md2_b <= bank2[addr_b];
        end
    end

    task automatic chk(input string nm, input int c, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s cycle %0d: got %0d, expected %0d", nm, c, act, exp);
        end
    endtask

    // Expected outputs follow from the position t of this cycle inside a run:
    // reads in t=1..N, pixel k shown at t=k+3, window k flagged at t=k+3+lat,
    // done at t=N+3+lat.
    task automatic checkDut(input int i, input int c,
                            input logic rd, input logic [7:0] addr, input logic e,
                            input logic signed [7:0] n0, input logic signed [7:0] n1,
                            input logic signed [7:0] n2, input logic ov,
                            input logic [3:0] orow, input logic [3:0] ocol,
                            input logic bz, input logic dn);
        string p = (i == 0) ? "A" : "B";
        int t = (run_start[i] >= 0) ? c - run_start[i] : -1000000;
        int L = lat[i];
        int k = t - 3 - L;
        int e_rd = (t >= 1 && t <= N) ? 1 : 0;
        int e_en = (t >= 3 && t <= N + 2) ? 1 : 0;
        int e_ov = 0, e_row = 0, e_col = 0;
        int e0 = last_next[i][0], e1 = last_next[i][1], e2 = last_next[i][2];
        if (e_en == 1) begin
            e0 = bank0[t-3];
            e1 = bank1[t-3];
            e2 = bank2[t-3];
        end
        if (k >= 0 && k < N && (k / M) >= K - 1 && (k % M) >= K - 1) begin
            e_ov  = 1;
            e_row = k / M - (K - 1);
            e_col = k % M - (K - 1);
        end
        chk({p, ".mem_rd"}, c, int'(rd), e_rd);
        chk({p, ".mem_addr"}, c, int'(addr), (e_rd == 1) ? t - 1 : 0);
        chk({p, ".en"}, c, int'(e), e_en);
        chk({p, ".next0"}, c, int'(n0), e0);
        chk({p, ".next1"}, c, int'(n1), e1);
        chk({p, ".next2"}, c, int'(n2), e2);
        chk({p, ".out_valid"}, c, int'(ov), e_ov);
        chk({p, ".out_row"}, c, int'(orow), e_row);
        chk({p, ".out_col"}, c, int'(ocol), e_col);
        chk({p, ".busy"}, c, int'(bz), (t >= 1 && t <= N + 2 + L) ? 1 : 0);
        chk({p, ".done"}, c, int'(dn), (t == N + 3 + L) ? 1 : 0);
    endtask

    task automatic updateModel(input int i, input int c);
        int t = (run_start[i] >= 0) ? c - run_start[i] : -1000000;
        if (t >= 3 && t <= N + 2) begin
            last_next[i][0] = bank0[t-3];
            last_next[i][1] = bank1[t-3];
            last_next[i][2] = bank2[t-3];
        end
        if (rst) begin
            run_start[i] = -1;
            for (int j = 0; j < 3; j++) last_next[i][j] = 0;
        end else if (start && !(t >= 1 && t <= N + 3 + lat[i])) begin
            run_start[i] = c;
        end
    endtask

    // Model comparison for both instances plus literal anchors per scenario.
    task automatic checkOutput(input int c);
        checkDut(0, c, rd_a, addr_a, en_a, n0_a, n1_a, n2_a, ov_a, row_a, col_a, busy_a, done_a);
        checkDut(1, c, rd_b, addr_b, en_b, n0_b, n1_b, n2_b, ov_b, row_b, col_b, busy_b, done_b);
        if (ov_a) ov_cnt_a++;
        if (ov_b) ov_cnt_b++;
        if (rd_a) rd_cnt_a++;
        if (done_a) done_cnt_a++;
        if (scen == 1) begin
            if (c == 64) begin
                chk("lit.first_valid", c, int'(ov_a), 1);
                chk("lit.first_row", c, int'(row_a), 0);
                chk("lit.first_col", c, int'(col_a), 0);
            end
            if (c == 133) chk("lit.next0_k130", c, int'(n0_a), 2);
            if (c == 199) begin
                chk("lit.last_valid", c, int'(ov_a), 1);
                chk("lit.last_row", c, int'(row_a), 9);
                chk("lit.last_col", c, int'(col_a), 9);
                chk("lit.done_early", c, int'(done_a), 0);
            end
            if (c == 200) chk("lit.done_a", c, int'(done_a), 1);
            if (c == 66)  chk("lit.lat3_first_valid", c, int'(ov_b), 1);
            if (c == 202) chk("lit.lat3_done", c, int'(done_b), 1);
        end
        if (scen == 2) begin
            if (c == 101) begin
                chk("lit.rst_busy", c, int'(busy_a), 0);
                chk("lit.rst_en", c, int'(en_a), 0);
            end
            if (c == 111) begin
                chk("lit.restart_rd", c, int'(rd_a), 1);
                chk("lit.restart_addr", c, int'(addr_a), 0);
            end
        end
        if (scen == 3 && c == 1) chk("lit.rst_over_start", c, int'(busy_a), 0);
    endtask

    task automatic applyStimulus(input int len);
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            run_start[i] = -1;
            for (int j = 0; j < 3; j++) last_next[i][j] = 0;
        end
        ov_cnt_a = 0; ov_cnt_b = 0; rd_cnt_a = 0; done_cnt_a = 0;
        for (int c = 0; c < len; c++) begin
            start = start_s[c];
            rst   = rst_s[c];
            @(negedge clk);
            checkOutput(c);
            updateModel(0, c);
            updateModel(1, c);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        start = 1'b0;
    endtask

    task automatic clearSchedule();
        for (int c = 0; c < MAXC; c++) begin
            start_s[c] = 1'b0;
            rst_s[c]   = 1'b0;
        end
    endtask

    initial begin
        lat[0] = 1;
        lat[1] = 3;
        for (int k = 0; k < 256; k++) begin
            bank0[k] = 8'(k % 128);
            bank1[k] = 8'($urandom);
            bank2[k] = 8'($urandom);
        end

        // Full run with re-pulsed start during READ, DRAIN and DONE.
        scen = 1;
        clearSchedule();
        start_s[0] = 1'b1; start_s[50] = 1'b1; start_s[199] = 1'b1; start_s[200] = 1'b1;
        applyStimulus(215);
        chk("lit.valid_count_a", 215, ov_cnt_a, 100);
        chk("lit.valid_count_b", 215, ov_cnt_b, 100);
        chk("lit.read_count", 215, rd_cnt_a, 196);
        chk("lit.done_count", 215, done_cnt_a, 1);

        // Abort mid-run, then a fresh run.
        scen = 2;
        clearSchedule();
        start_s[0] = 1'b1; rst_s[100] = 1'b1; start_s[110] = 1'b1;
        applyStimulus(330);
        chk("lit.abort_done_count", 330, done_cnt_a, 1);

        // Reset and start together, then a later start.
        scen = 3;
        clearSchedule();
        rst_s[0] = 1'b1; start_s[0] = 1'b1; start_s[5] = 1'b1;
        applyStimulus(220);

        // Random bank contents, start pulses and occasional resets.
        scen = 4;
        for (int k = 0; k < 256; k++) begin
            bank0[k] = 8'($urandom);
            bank1[k] = 8'($urandom);
            bank2[k] = 8'($urandom);
        end
        clearSchedule();
        for (int c = 0; c < 2000; c++) begin
            start_s[c] = ($urandom_range(0, 99) == 0);
            rst_s[c]   = ($urandom_range(0, 599) == 0);
        end
        applyStimulus(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fmap_streamer3.md
FMAP_STREAMER3 -- requirements
Module: fmap_streamer3

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, pixel width.
REQ-002 SHALL have parameter MAP_SIZE, default 14, input map side length.
REQ-003 SHALL have parameter KERNEL, default 5, convolution window side.
REQ-004 SHALL have parameter ADDR_WIDTH, default 8, memory address width, with 2^ADDR_WIDTH >= MAP_SIZE*MAP_SIZE.
REQ-005 SHALL have parameter CONV_LAT, default 1, cycles from a consumer en edge to the matching valid convValue.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, single-cycle request to stream one 3-channel map.
REQ-009 SHALL have port mem_rd, output, 1, read strobe to the three channel banks.
REQ-010 SHALL have port mem_addr, output, ADDR_WIDTH, row-major pixel address shared by all banks.
REQ-011 SHALL have ports mem_data0, mem_data1, mem_data2, input, BIT_WIDTH signed each, bank read data valid one cycle after mem_rd.
REQ-012 SHALL have ports next0, next1, next2, output, BIT_WIDTH signed each, pixel stream to the 5x5x3 convolution consumer.
REQ-013 SHALL have port en, output, 1, latch enable for the consumer, high when next0..2 carry a valid pixel.
REQ-014 SHALL have port out_valid, output, 1, high when the consumer convValue this cycle is a fully-inside window.
REQ-015 SHALL have ports out_row, out_col, output, clog2(MAP_SIZE-KERNEL+1) each, output-map coordinate of the out_valid window.
REQ-016 SHALL have port busy, output, 1, high in READ and DRAIN.
REQ-017 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-018 SHALL implement FSM IDLE -> READ on start; READ -> DRAIN after address N-1, N=MAP_SIZE*MAP_SIZE; DRAIN -> DONE when the pipeline is empty; DONE -> IDLE after one cycle.
REQ-019 SHALL ignore start in READ, DRAIN and DONE; no restart or queueing.
REQ-020 SHALL, with start high in cycle 0, drive mem_rd=1 and mem_addr=c-1 in cycles 1..N, one address per cycle, no gaps.
REQ-021 SHALL register mem_data0..2 into next0..2 so pixel k appears with en=1 in cycle k+3; en SHALL be 0 otherwise.
REQ-022 SHALL hold next0..2 at their last value when en=0.
REQ-023 SHALL track pixel row r and column c, wrapping c to 0 and incrementing r at c=MAP_SIZE-1.
REQ-024 SHALL assert out_valid for pixel k exactly when r>=KERNEL-1 and c>=KERNEL-1, in cycle k+3+CONV_LAT, with out_row=r-(KERNEL-1) and out_col=c-(KERNEL-1).
REQ-025 SHALL carry valid/row/col through a CONV_LAT-deep shift pipeline; out_row/out_col SHALL be 0 when out_valid=0.
REQ-026 SHALL produce exactly (MAP_SIZE-KERNEL+1)^2 out_valid pulses per run (100 at defaults), in row-major order.
REQ-027 SHALL remain in DRAIN until the last pixel out_valid slot has passed, then assert done in cycle N+3+CONV_LAT (200 at defaults).
REQ-028 SHALL keep mem_addr at 0 whenever mem_rd=0.

Reset
REQ-029 SHALL, on rst high at a clock edge, enter IDLE and clear mem_rd, mem_addr, next0..2, en, out_valid, out_row, out_col, busy and done to 0, including all pipeline stages.
REQ-030 SHALL give rst priority over start in the same cycle.
REQ-031 SHALL, on rst mid-run, abort with no further en, out_valid or done pulses from that run.

Verification
REQ-032 SHALL verify defaults, bank k holding value k mod 128: start in cycle 0 -> mem_rd cycles 1..196, en cycles 3..198, next0=k in cycle k+3, done in cycle 200 only.
REQ-033 SHALL verify windowing: first out_valid in cycle 64 with (0,0), last in cycle 199 with (9,9), 100 pulses total, none in cycles with c<4.
REQ-034 SHALL verify start re-pulsed in cycles 50 and 199 -> ignored; a single run of 196 reads.
REQ-035 SHALL verify rst high in cycle 100 -> all outputs 0 from cycle 101; no done; a fresh start in cycle 110 -> mem_addr=0 in cycle 111.
REQ-036 SHALL verify rst and start both high in cycle 0 -> stays IDLE, busy=0 in cycle 1.
REQ-037 SHALL verify CONV_LAT=3 -> first out_valid in cycle 66, done in cycle 202.
